// File: rtl/frontend_inst_queue.sv
// Multi-port in-order instruction queue between decode and issue.
// Holed write masks are compacted on entry, and reads are clamped to the current occupancy.
module frontend_inst_queue #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 8,
  parameter int WRITE_PORT   = 2,
  parameter int READ_PORT    = 2,
  parameter int AFULL_THRESH = DEPTH - WRITE_PORT
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush_i,
  input  logic [WRITE_PORT-1:0]                 write_valid_i,
  input  logic [WRITE_PORT-1:0][DATA_WIDTH-1:0] write_data_i,
  output logic                                  write_ready_o,
  output logic [READ_PORT-1:0]                  read_valid_o,
  output logic [READ_PORT-1:0][DATA_WIDTH-1:0]  read_data_o,
  input  logic [$clog2(READ_PORT+1)-1:0]        read_num_i,
  output logic [$clog2(DEPTH+1)-1:0]            count_o,
  output logic                                  almost_full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  do_write;
  logic [CNT_W-1:0]      wr_cnt;
  logic [CNT_W-1:0]      rd_req;
  logic [CNT_W-1:0]      rd_n;
  logic [PTR_W-1:0]      wr_off;

  // Ready is judged on the pre-read count, so a same-cycle read never opens room.
  assign write_ready_o = int'(count_q) <= (DEPTH - WRITE_PORT);
  assign almost_full_o = int'(count_q) >= AFULL_THRESH;
  assign count_o       = count_q;
  assign do_write      = write_ready_o && (|write_valid_i) && !flush_i;
  assign wr_cnt        = do_write ? CNT_W'($countones(write_valid_i)) : '0;
  assign rd_req        = CNT_W'(read_num_i);
  assign rd_n          = (rd_req > count_q) ? count_q : rd_req;

  always_comb begin
    for (int i = 0; i < READ_PORT; i++) begin
      read_valid_o[i] = int'(count_q) > i;
      read_data_o[i]  = mem_q[head_q + PTR_W'(i)];
    end
  end

  // Valid slots land at consecutive positions from tail, skipping holes in the mask.
  always_comb begin
    mem_d  = mem_q;
    wr_off = '0;
    if (do_write) begin
      for (int i = 0; i < WRITE_PORT; i++) begin
        if (write_valid_i[i]) begin
          mem_d[tail_q + wr_off] = write_data_i[i];
          wr_off                 = wr_off + 1'b1;
        end
      end
    end
  end

  always_comb begin
    head_d  = head_q + PTR_W'(rd_n);
    tail_d  = tail_q + PTR_W'(wr_cnt);
    count_d = count_q + wr_cnt - rd_n;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage has no reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: doc/frontend_inst_queue.md
# frontend_inst_queue

Parametrised multi-port instruction queue between the decode register and the issue stage of the frontend. It generalises the fixed 2-in/2-out issue FIFO: arbitrary port counts and depth, per-slot write masks with hole compaction inside the queue, occupancy and almost-full reporting, and clamped reads. Decoded packets enter in program order. The oldest READ_PORT entries are presented to issue every cycle.

## Interface
- DATA_WIDTH, 32: bits per entry (the team instantiates it with $bits(inst_t)).
- DEPTH, 8: total entries. Must be a power of two and ≥ 2·max(WRITE_PORT, READ_PORT).
- WRITE_PORT, 2: write slots per cycle.
- READ_PORT, 2: read slots per cycle.
- AFULL_THRESH, DEPTH-WRITE_PORT: almost_full_o asserts when count ≥ this value.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush_i  in  1  discard all contents (redirect or rst_jmp).
- write_valid_i  in  WRITE_PORT  per-slot valid mask. Any pattern is legal, including holes.
- write_data_i  in  WRITE_PORT×DATA_WIDTH  slot i holds data[i]. Lower slot is older.
- write_ready_o  out  1  asserted when free entries ≥ WRITE_PORT.
- read_valid_o  out  READ_PORT  bit i set when count > i (thermometer code).
- read_data_o  out  READ_PORT×DATA_WIDTH  slot i carries the i-th oldest entry.
- read_num_i  in  $clog2(READ_PORT+1)  number of entries consumed this cycle.
- count_o  out  $clog2(DEPTH+1)  current occupancy.
- almost_full_o  out  1  count_o ≥ AFULL_THRESH.

## Operation
- Internal state: circular storage, head and tail pointers of log2(DEPTH) bits, and a count register. Pointers wrap modulo DEPTH.
- Write: accepted when write_ready_o is high and write_valid_i is non-zero.
  - Valid slots are compacted in slot order and stored at tail, tail+1, … .
  - tail and count advance by popcount(write_valid_i).
  - When write_ready_o is low, the write is dropped whole. There are no partial writes.
- Read: the effective consume count is n = min(read_num_i, count). Excess requests are clamped silently, with no underflow. head advances by n.
- Simultaneous read and write: both are applied in the same cycle.
  - Next count = count + wcnt − n.
  - write_ready_o is computed from the pre-read count, which is conservative. A same-cycle read never enables a write.
- Flush: head, tail and count go to 0 on the next edge. Flush overrides any same-cycle write or read.
- Reset: same effect as flush. Storage contents are not cleared.
- All outputs are functions of registered state only. No combinational path runs from any input to any output.

## Timing
- Reset and flush values of the outputs: write_ready_o=1, read_valid_o=0, count_o=0, almost_full_o=0 (when AFULL_THRESH>0).
- read_data_o is don't-care for slots where read_valid_o is 0.
- Latency: an entry written at edge N appears on read_valid_o and read_data_o in the cycle after edge N. There is no bypass.
- Throughput: WRITE_PORT entries in and READ_PORT entries out per cycle, sustained.
- Full boundary: write_ready_o falls once count > DEPTH−WRITE_PORT. It rises in the cycle after reads bring count back to ≤ DEPTH−WRITE_PORT.
- Empty boundary: read_valid_o is 0 and read_num_i is ignored.
- Wrap-around: a multi-entry write or read that straddles index DEPTH−1→0 must preserve order.
- rst asserted mid-operation takes effect at the next edge regardless of other inputs.

## Test plan
Configuration for all scenarios: WRITE_PORT=2, READ_PORT=2, DEPTH=8, AFULL_THRESH=6.
- Holed write: after reset, write_valid_i=2'b10 with data {B,A} → next cycle read_valid_o=2'b01, read_data_o[0]=B, count_o=1.
- Fill to full: write 2'b11 for four cycles with read_num_i=0.
  - Count sequence is 2, 4, 6, 8.
  - almost_full_o rises when count reaches 6.
  - write_ready_o=0 at count 8.
  - A fifth write is dropped and count stays 8.
- Concurrent read/write at count 6: write 2'b11 with read_num_i=2 → count stays 6 and the oldest two entries leave in order. Then at count 7, write_ready_o=0 even while read_num_i=2.
- Wrap order: stream 20 sequential values (2 per cycle, masks varied including 2'b01) while consuming read_num_i=1 per cycle when valid → output sequence equals input sequence, with no loss across pointer wrap.
- Clamp: at count 1, read_num_i=2 → count 0 next cycle, read_valid_o=0, and no spurious entry afterwards.
- Flush/reset priority: at count 5, assert flush_i together with a 2'b11 write and read_num_i=2 → count_o=0, read_valid_o=0, write_ready_o=1 next cycle. Repeat with rst high mid-stream and expect the same result.
